// File: rtl/joypad_reader.sv
// joypad_reader: scans two NES-style serial pads (latch/clock/data) into registered switch bytes.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start             single-cycle scan request, honoured only when idle
//   data_p1, data_p2  active-low serial data from pad 1 / pad 2
//   pad_latch         parallel-load strobe shared by both pads
//   pad_clk           shift clock shared by both pads
//   switches_p1/p2    active-high button bytes, bit i = i-th bit shifted out
//   valid             one-cycle pulse when a scan completes
//   busy              high while a scan is in progress
// Optional: define JOYPAD_DEBOUNCE_EN to publish a pad byte only when two
// consecutive scans agree.
module joypad_reader #(
    parameter int HALF_PERIOD = 6,
    parameter int NBITS       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             data_p1,
    input  logic             data_p2,
    output logic             pad_latch,
    output logic             pad_clk,
    output logic [NBITS-1:0] switches_p1,
    output logic [NBITS-1:0] switches_p2,
    output logic             valid,
    output logic             busy
);
    localparam int TW = $clog2(2 * HALF_PERIOD);
    localparam int IW = NBITS > 1 ? $clog2(NBITS) : 1;
    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
    state_t          state, next_state;
    logic [TW-1:0]   timer, limit;
    logic [IW-1:0]   index;
    logic            phase_end, last_bit;
    logic [1:0]      sync_p1, sync_p2;
    logic [NBITS-1:0] shift_p1, shift_p2;
`ifdef JOYPAD_DEBOUNCE_EN
    logic [NBITS-1:0] prev_p1, prev_p2;
`endif
    assign limit     = state == LATCH ? TW'(2 * HALF_PERIOD - 1) : TW'(HALF_PERIOD - 1);
    assign phase_end = timer == limit;
    assign last_bit  = index == IW'(NBITS - 1);
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LATCH;
            LATCH:   if (phase_end) next_state = LOW;
            LOW:     if (phase_end) next_state = HIGH;
            HIGH:    if (phase_end) next_state = last_bit ? DONE : LOW;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            index   <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            state   <= next_state;
            // the timer restarts on every phase change so each phase gets its full length
            timer   <= (next_state != state || state == IDLE) ? '0 : timer + TW'(1);
            sync_p1 <= {sync_p1[0], data_p1};
            sync_p2 <= {sync_p2[0], data_p2};
            if (state == LATCH)
                index <= '0;
            else if (state == HIGH && phase_end && !last_bit)
                index <= index + IW'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_p1 <= '0;
            shift_p2 <= '0;
        end else if (state == LOW && phase_end) begin
            // sample both pads together at the end of the low half, inverting to active-high
            shift_p1[index] <= ~sync_p1[1];
            shift_p2[index] <= ~sync_p2[1];
        end
    end
    // outputs are registered from next_state so pad strobes are glitch-free and
    // switches change on the same edge that raises valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            switches_p1 <= '0;
            switches_p2 <= '0;
`ifdef JOYPAD_DEBOUNCE_EN
            prev_p1     <= '0;
            prev_p2     <= '0;
`endif
        end else begin
            pad_latch <= next_state == LATCH;
            pad_clk   <= next_state == HIGH;
            valid     <= next_state == DONE;
            busy      <= next_state != IDLE;
            if (next_state == DONE) begin
`ifdef JOYPAD_DEBOUNCE_EN
                prev_p1 <= shift_p1;
                prev_p2 <= shift_p2;
                if (shift_p1 == prev_p1) switches_p1 <= shift_p1;
                if (shift_p2 == prev_p2) switches_p2 <= shift_p2;
`else
                switches_p1 <= shift_p1;
                switches_p2 <= shift_p2;
`endif
            end
        end
    end
endmodule

// File: tb/tb_joypad_reader.sv
// tb_joypad_reader: directed self-checking bench for joypad_reader with a behavioural pad model.
module tb_joypad_reader;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0] press1 = 8'h00, press2 = 8'h00;
    logic [3:0] pad_cnt = 4'd8;
    logic       data_p1, data_p2, pad_latch, pad_clk, valid, busy;
    logic [7:0] switches_p1, switches_p2;
    int n_cmp = 0, n_bad = 0;
    int latch_cnt, first_latch, second_latch, clk_rises, clk_high, valid_cnt, valid_cyc, busy_cnt, overlap;
    logic [7:0] pre1, pre2, exp1 = 8'h00, exp2 = 8'h00, prev1 = 8'h00, prev2 = 8'h00;
    logic       any_high, found;

    joypad_reader dut (
        .clk(clk), .reset(reset), .start(start), .data_p1(data_p1), .data_p2(data_p2),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .switches_p1(switches_p1),
        .switches_p2(switches_p2), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // shift-register pad: latch reloads, each pad_clk rise advances one bit, pressed = low
    always @(posedge pad_latch or posedge pad_clk) pad_cnt <= pad_latch ? 4'd0 : pad_cnt + 4'd1;
    assign data_p1 = pad_cnt < 4'd8 ? ~press1[pad_cnt[2:0]] : 1'b1;
    assign data_p2 = pad_cnt < 4'd8 ? ~press2[pad_cnt[2:0]] : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_done();
`ifdef JOYPAD_DEBOUNCE_EN
        if (press1 == prev1) exp1 = press1;
        if (press2 == prev2) exp2 = press2;
        prev1 = press1;
        prev2 = press2;
`else
        exp1 = press1;
        exp2 = press2;
`endif
    endtask

    // pulses start in cycle 0, observes cycles 1..ncyc at negedge; extra starts at s1/s2/s3, reset at rst_at
    task automatic scan(input int s1, input int s2, input int s3, input int rst_at, input int ncyc);
        logic pl = 1'b0, pc = 1'b0;
        latch_cnt = 0; clk_rises = 0; clk_high = 0; valid_cnt = 0; busy_cnt = 0; overlap = 0;
        first_latch = -1; second_latch = -1; valid_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (pad_latch && !pl) begin
                if (first_latch < 0) first_latch = c;
                else second_latch = c;
            end
            if (pad_latch && c <= 110) latch_cnt++;
            if (pad_clk && !pc && c <= 110) clk_rises++;
            if (pad_clk && c <= 110) clk_high++;
            if (busy && c <= 110) busy_cnt++;
            if (pad_latch && pad_clk) overlap++;
            if (valid) begin
                valid_cnt++;
                if (valid_cyc < 0) valid_cyc = c;
            end
            if (c == 108) begin
                pre1 = switches_p1;
                pre2 = switches_p2;
            end
            pl = pad_latch;
            pc = pad_clk;
            start = (c == s1 || c == s2 || c == s3);
            if (c == rst_at) reset = 1'b1;
            else if (c == rst_at + 1) reset = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = valid;
        end
    endtask

    initial begin
        // asynchronous reset asserted between edges
        #12 reset = 1'b1;
        #1;
        check("rst_latch", pad_latch, 0);
        check("rst_clk", pad_clk, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sw1", switches_p1, 0);
        check("rst_sw2", switches_p2, 0);
        @(negedge clk) reset = 1'b0;
        any_high = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_high |= pad_latch | pad_clk | valid | busy | (|switches_p1) | (|switches_p2);
        end
        check("idle_quiet", any_high, 0);

        // basic scan: pad 1 bit 4, pad 2 unplugged-equivalent (all high)
        press1 = 8'h10; press2 = 8'h00;
        scan(-1, -1, -1, -10, 115);
        model_done();
        check("basic_first_latch", first_latch, 1);
        check("basic_latch_len", latch_cnt, 12);
        check("basic_clk_pulses", clk_rises, 8);
        check("basic_clk_high", clk_high, 48);
        check("basic_valid_cyc", valid_cyc, 109);
        check("basic_valid_cnt", valid_cnt, 1);
        check("basic_busy_len", busy_cnt, 109);
        check("basic_overlap", overlap, 0);
        check("basic_sw1", switches_p1, exp1);
        check("basic_sw2", switches_p2, exp2);

        // full alternating patterns, then hold while idle
        press1 = 8'h55; press2 = 8'hAA;
        scan(-1, -1, -1, -10, 115);
        model_done();
        check("full_valid_cyc", valid_cyc, 109);
        check("full_sw1", switches_p1, exp1);
        check("full_sw2", switches_p2, exp2);
        press1 = 8'h00; press2 = 8'h00;
        repeat (20) @(negedge clk);
        check("hold_sw1", switches_p1, exp1);
        check("hold_sw2", switches_p2, exp2);

        // start collisions mid-scan and in DONE ignored; first idle cycle accepted
        press1 = 8'h81; press2 = 8'h7E;
        scan(40, 109, 110, -10, 125);
        check("coll_pre_sw1", pre1, exp1);
        check("coll_pre_sw2", pre2, exp2);
        model_done();
        check("coll_valid_cnt", valid_cnt, 1);
        check("coll_valid_cyc", valid_cyc, 109);
        check("coll_relatch", second_latch, 111);
        check("coll_sw1", switches_p1, exp1);
        check("coll_sw2", switches_p2, exp2);
        wait_valid(200);
        check("coll_second_done", found, 1);
        model_done();
        @(negedge clk);
        check("coll2_sw1", switches_p1, exp1);
        check("coll2_sw2", switches_p2, exp2);

        // reset in the middle of a scan publishes nothing
        press1 = 8'hFF; press2 = 8'hFF;
        scan(-1, -1, -1, 60, 125);
        exp1 = 8'h00; exp2 = 8'h00; prev1 = 8'h00; prev2 = 8'h00;
        check("abort_valid_cnt", valid_cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_sw1", switches_p1, 8'h00);
        check("abort_sw2", switches_p2, 8'h00);

        // debounce sequence on pad 1
        press2 = 8'h00;
        press1 = 8'h01;
        scan(-1, -1, -1, -10, 115);
        model_done();
        check("deb1_valid", valid_cnt, 1);
`ifdef JOYPAD_DEBOUNCE_EN
        check("deb1_sw1", switches_p1, 8'h00);
`else
        check("deb1_sw1", switches_p1, 8'h01);
`endif
        scan(-1, -1, -1, -10, 115);
        model_done();
        check("deb2_sw1", switches_p1, 8'h01);
        press1 = 8'h02;
        scan(-1, -1, -1, -10, 115);
        model_done();
        check("deb3_valid", valid_cnt, 1);
`ifdef JOYPAD_DEBOUNCE_EN
        check("deb3_sw1", switches_p1, 8'h01);
`else
        check("deb3_sw1", switches_p1, 8'h02);
`endif
        check("deb3_model_sw1", switches_p1, exp1);
        check("deb3_sw2", switches_p2, exp2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
